apb_master_arb: RTL and testbench

- Two-requester APB master that shares one APB bus between requesters 0 and 1, using round-robin arbitration.
- Converts each granted request into a standard APB transfer: IDLE, then SETUP, then ACCESS.
- Waits for pready, returns read data and a done pulse to the owning requester, and aborts with an error if the slave stalls too long.
- Sits between internal bus clients and the 8-bit-address / 8-bit-data APB slave memory.

---
 rtl/apb_master_arb.sv | 172 +++++++++++++++++
 tb/tb_apb_master_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester round-robin APB master with wait-state timeout
//
// Shares one APB bus between requesters 0 and 1. Each granted request is
// turned into an APB transfer (IDLE -> SETUP -> ACCESS). A one-cycle done
// pulse (with err on timeout) and read data go back to the owner.
//
// Ports:
//   pclk, presetn              clock (rising edge), async active-low reset
//   reqN_valid/write/addr/wdata  requester N transfer request (held until done)
//   reqN_done/err/rdata        requester N completion pulse, timeout flag, read data
//   psel, penable, pwrite      APB control
//   paddr, pwdata, prdata      APB address / write data / read data
//   pready                     APB slave ready
module apb_master_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic [4:0]        r_wait_cnt, w_wait_cnt_nxt;

  logic              w_psel_nxt, w_penable_nxt, w_pwrite_nxt;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic              w_done0_nxt, w_done1_nxt, w_err0_nxt, w_err1_nxt;
  logic [DATA_W-1:0] w_rdata0_nxt, w_rdata1_nxt;

  // A requester whose done is high this cycle is still holding valid from the
  // transfer being retired; it must not be granted again on that same cycle.
  logic w_elig0, w_elig1, w_grant1;
  assign w_elig0  = req0_valid & ~req0_done;
  assign w_elig1  = req1_valid & ~req1_done;
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_psel_nxt       = psel;
    w_penable_nxt    = penable;
    w_pwrite_nxt     = pwrite;
    w_paddr_nxt      = paddr;
    w_pwdata_nxt     = pwdata;
    w_done0_nxt      = 1'b0;
    w_done1_nxt      = 1'b0;
    w_err0_nxt       = 1'b0;
    w_err1_nxt       = 1'b0;
    w_rdata0_nxt     = req0_rdata;
    w_rdata1_nxt     = req1_rdata;

    case (r_state)
      ST_IDLE: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        if (w_elig0 || w_elig1) begin
          w_owner_nxt      = w_grant1;
          w_last_grant_nxt = w_grant1;
          w_pwrite_nxt     = w_grant1 ? req1_write : req0_write;
          w_paddr_nxt      = w_grant1 ? req1_addr  : req0_addr;
          w_pwdata_nxt     = w_grant1 ? req1_wdata : req0_wdata;
          w_psel_nxt       = 1'b1;
          w_state_nxt      = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_penable_nxt  = 1'b1;
        w_wait_cnt_nxt = 5'd0;
        w_state_nxt    = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready on the last allowed cycle still counts as a normal completion.
        if (pready || (r_wait_cnt == TO_LAST)) begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
          if (r_owner) begin
            w_done1_nxt = 1'b1;
            w_err1_nxt  = ~pready;
            if (pready && !pwrite) w_rdata1_nxt = prdata;
          end else begin
            w_done0_nxt = 1'b1;
            w_err0_nxt  = ~pready;
            if (pready && !pwrite) w_rdata0_nxt = prdata;
          end
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 5'd1;
        end
      end

      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= 5'd0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_err     <= 1'b0;
      req1_err     <= 1'b0;
      req0_rdata   <= '0;
      req1_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      psel         <= w_psel_nxt;
      penable      <= w_penable_nxt;
      pwrite       <= w_pwrite_nxt;
      paddr        <= w_paddr_nxt;
      pwdata       <= w_pwdata_nxt;
      req0_done    <= w_done0_nxt;
      req1_done    <= w_done1_nxt;
      req0_err     <= w_err0_nxt;
      req1_err     <= w_err1_nxt;
      req0_rdata   <= w_rdata0_nxt;
      req1_rdata   <= w_rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed table-driven bench for apb_master_arb
module tb_apb_master_arb;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_done, req0_err, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic       psel, penable, pwrite, pready;
  logic [7:0] paddr, pwdata, prdata;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb_master_arb dut (
    .pclk(pclk), .presetn(presetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  typedef struct {
    logic       rq;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    int         waits;      // wait states before pready; 99 = never ready
    int         exp_acc;    // expected number of ACCESS cycles
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic seen_done, stable, other, e;
    logic [7:0] rd;
    int acc;
    if (v.rq) begin
      req1_valid = 1'b1; req1_write = v.wr; req1_addr = v.addr; req1_wdata = v.wdata;
    end else begin
      req0_valid = 1'b1; req0_write = v.wr; req0_addr = v.addr; req0_wdata = v.wdata;
    end
    prdata = v.prdata;
    pready = 1'b0;
    @(negedge pclk);
    chk($sformatf("v%0d_setup_phase", idx), {psel, penable}, 2'b10);
    chk($sformatf("v%0d_paddr", idx), paddr, v.addr);
    chk($sformatf("v%0d_pwrite", idx), pwrite, v.wr);
    chk($sformatf("v%0d_pwdata", idx), pwdata, v.wdata);
    acc = 0; seen_done = 1'b0; stable = 1'b1; other = 1'b0; e = 1'b0; rd = '0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      @(negedge pclk);
      e  = v.rq ? req1_err : req0_err;
      rd = v.rq ? req1_rdata : req0_rdata;
      other = other | (v.rq ? (req0_done | req0_err) : (req1_done | req1_err));
      if (v.rq ? req1_done : req0_done) begin
        seen_done = 1'b1;
        chk($sformatf("v%0d_psel_after_done", idx), {psel, penable}, 2'b00);
      end else if (psel && penable && paddr == v.addr && pwrite == v.wr && pwdata == v.wdata) begin
        acc++;
        pready = (acc == v.waits + 1);
      end else begin
        stable = 1'b0;
      end
    end
    chk($sformatf("v%0d_done_seen", idx), seen_done, 1'b1);
    chk($sformatf("v%0d_access_cycles", idx), acc, v.exp_acc);
    chk($sformatf("v%0d_bus_stable", idx), stable, 1'b1);
    chk($sformatf("v%0d_err", idx), e, v.exp_err);
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d_other_quiet", idx), other, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0; pready = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    int nd, both;
    int pos[4];
    logic [3:0] order;
    logic any_done;

    //          rq    wr    addr   wdata  prdata waits acc err   rdata
    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 0,    1,  1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 2,    3,  1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 8'h22, 8'h00, 8'h5A, 0,    1,  1'b0, 8'h5A};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 8'h0F, 8'hEE, 1,    2,  1'b0, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, 4,    5,  1'b0, 8'hC3};
    vecs[5] = '{1'b1, 1'b0, 8'h44, 8'h00, 8'h99, 99,   16, 1'b1, 8'hC3};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h77, 8'h66, 99,   16, 1'b1, 8'h5A};
    vecs[7] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h11, 15,   16, 1'b0, 8'h11};

    presetn = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    prdata = '0; pready = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    chk("reset_bus", {psel, penable, pwrite, paddr, pwdata}, 19'd0);
    chk("reset_done_err", {req0_done, req0_err, req1_done, req1_err}, 4'd0);
    chk("reset_rdata", {req0_rdata, req1_rdata}, 16'd0);

    // Contention from reset: both held, grants alternate starting with req0.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'hA0; req0_wdata = 8'h01;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'hB1; req1_wdata = 8'h02;
    pready = 1'b1;
    nd = 0; both = 0; order = '0;
    for (int i = 0; i < 4; i++) pos[i] = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge pclk);
      if (c == 1) chk("cont_first_paddr", paddr, 8'hA0);
      if (req0_done && req1_done) both++;
      if (req0_done || req1_done) begin
        if (nd < 4) begin
          order[nd] = req1_done;
          pos[nd] = c;
        end
        nd++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge pclk);
    pready = 1'b0;
    chk("cont_done_count", nd, 4);
    chk("cont_order", order, 4'b1010);
    chk("cont_no_overlap", both, 0);
    chk("cont_first_done_cycle", pos[0], 3);
    chk("cont_last_done_cycle", pos[3], 12);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Retire masking: req0 keeps valid high through its done cycle.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h5C; req0_wdata = 8'h3E;
    pready = 1'b1;
    repeat (3) @(negedge pclk);
    chk("mask_done", req0_done, 1'b1);
    @(negedge pclk);
    chk("mask_no_regrant", psel, 1'b0);
    @(negedge pclk);
    chk("mask_next_setup", {psel, penable}, 2'b10);
    req0_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("mask_second_done", req0_done, 1'b1);
    @(negedge pclk);
    pready = 1'b0;

    // Reset in the middle of an ACCESS phase.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h55;
    repeat (2) @(negedge pclk);
    chk("rst_in_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    chk("rst_async_drop", {psel, penable}, 2'b00);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h66; req0_wdata = 8'h99;
    any_done = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      any_done = any_done | req0_done | req1_done;
    end
    presetn = 1'b1;
    pready = 1'b1;
    @(negedge pclk);
    any_done = any_done | req0_done | req1_done;
    chk("rst_req0_wins", {psel, penable, paddr}, {2'b10, 8'h66});
    @(negedge pclk);
    any_done = any_done | req0_done | req1_done;
    chk("rst_no_stale_done", any_done, 1'b0);
    @(negedge pclk);
    chk("rst_req0_done", {req0_done, req1_done}, 2'b10);
    req0_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_req1_served", {req0_done, req1_done}, 2'b01);
    req1_valid = 1'b0;
    pready = 1'b0;
    repeat (2) @(negedge pclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule
